mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single data-memory port (sram-style req/ready) between the CPU instruction-fetch path (IF) and the load/store path (LS).
- Arbitrates between the two requesters round-robin.
- Converts byte addresses to word addresses and byte enables.
- Extracts and zero-extends bytes on reads.
- Rejects misaligned or out-of-range accesses.
- Aborts memory transactions that do not complete within a timeout.
- Sits between the CPU FSM (FETCH/EXECUTE stages) and the memory instance.

Parameters:
MEM_ADDR_W, 18, word-address width driven to memory (byte space is 2^(MEM_ADDR_W+2)).
TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready before an error response (≥1).

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  32  fetch byte address (word read)
if_gnt  out  1  combinational accept pulse for IF
if_rvalid  out  1  one-cycle response pulse for IF
if_rdata  out  32  fetch read data
if_err  out  1  IF error, valid with if_rvalid
ls_req  in  1  load/store request; held with its fields until ls_gnt
ls_we  in  1  1 = store
ls_byte  in  1  1 = byte access, 0 = word access
ls_addr  in  32  byte address
ls_wdata  in  32  store data (byte access uses [7:0])
ls_gnt  out  1  combinational accept pulse for LS
ls_rvalid  out  1  one-cycle response pulse for LS (loads and stores)
ls_rdata  out  32  load data (zero-extended for byte loads)
ls_err  out  1  LS error, valid with ls_rvalid
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write
mem_be  out  4  byte enables, lane 0 = bits [7:0] (little-endian)
mem_addr  out  MEM_ADDR_W  word address = byte_addr[MEM_ADDR_W+1:2]
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid when mem_ready
mem_ready  in  1  memory completion strobe

Behaviour:
Reset (asynchronous): all outputs 0, state IDLE, last_grant = IF, timeout counter 0. Asserting reset mid-transaction drops the transaction; no response is issued.

States:
- IDLE: grants at most one requester (gnt is combinational and asserted only in IDLE).
  - Only one req asserted → grant it.
  - Both asserted → grant the requester not equal to last_grant. After reset, LS wins the first conflict.
  - On grant: capture owner, we, byte, addr and wdata; update last_grant.
  - Captured access is bad (word access with addr[1:0]≠0, or addr[31:MEM_ADDR_W+2]≠0) → go to RESP with err=1, rdata=0. No mem_req is issued.
  - Captured access is good → go to BUSY.
- BUSY: mem_req=1, with mem_we/mem_be/mem_addr/mem_wdata held stable and registered.
  - mem_be: word access = 4'b1111. Byte access = 1<<addr[1:0].
  - mem_wdata: byte store replicates wdata[7:0] on all four lanes. Word store passes wdata through. Reads drive 0.
  - IF accesses are always word reads.
  - mem_ready=1 → latch the result, deassert mem_req next cycle, go to RESP with err=0.
  - Read result: word = mem_rdata. Byte = {24'b0, selected lane}.
  - Counter increments each BUSY cycle without ready. Reaching TIMEOUT → RESP with err=1, rdata=0.
  - mem_ready in the same cycle the counter expires: ready wins, and the response has no error.
- RESP: exactly one cycle. Owner's rvalid=1 with rdata/err. The other requester's response outputs stay 0. Next state IDLE; counter cleared.
- rdata/err hold their value until the next response. Only rvalid pulses.

Timing:
- Minimum latency: gnt at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, rvalid at cycle 2, next grant possible at cycle 3.
- Error response for a bad access: rvalid at cycle 1.
- Requests asserted while not in IDLE wait. No queueing beyond the request being held by the requester.
- A store response carries rdata=0.

Decomposition:
- Package mem_arb_pkg:
  - State encodings IDLE/BUSY/RESP (2 bits).
  - Owner encoding OWN_IF=0, OWN_LS=1.
  - Byte-enable function be_of(byte, addr[1:0]).
  - Lane-extract function.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], en, last_grant register.
  - Output: one-hot gnt.
  - Updates last_grant on an accepted grant.

Test Plan:
1. IF read at if_addr 0x100; mem_ready asserted 2 cycles after mem_req with mem_rdata 0xE3A01005 → mem_addr 0x40, mem_be 4'b1111, then if_rvalid pulse with if_rdata 0xE3A01005, if_err 0.
2. if_req and ls_req both asserted and held continuously from reset, memory ready immediately → grants go LS, IF, LS, IF. Neither requester is granted twice in a row.
3. LS byte store at 0x203 with ls_wdata 0x000000AB → mem_addr 0x80, mem_be 4'b1000, mem_wdata 0xABABABAB, mem_we 1, then ls_rvalid with ls_err 0.
4. LS byte load at 0x202 with mem_rdata 0x11223344 → mem_be 4'b0100, ls_rdata 0x00000022.
5. LS word load at 0x102, then at 0x0100_0000 (MEM_ADDR_W=18) → each gives ls_rvalid one cycle after gnt with ls_err 1 and ls_rdata 0. mem_req never rises.
6. TIMEOUT=8 with mem_ready stuck at 0 → mem_req high 8 cycles, then if_rvalid with if_err 1. Repeat and assert mem_ready on the 8th cycle → no error. Drop n_reset mid-BUSY → all outputs 0 immediately and no response pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and lane helpers for the IF/LS data-memory arbiter.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   function automatic logic [3:0] be_of(input logic is_byte, input logic [1:0] off);
      return is_byte ? (4'b0001 << off) : 4'b1111;
   endfunction

   // Little-endian lane select: offset 0 is bits [7:0].
   function automatic logic [7:0] lane_of(input logic [31:0] data, input logic [1:0] off);
      return data[{off, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a conflict the requester that did not win last time gets the grant.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       n_reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == OWN_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt[OWN_LS]) begin
         last_grant_d = OWN_LS;
      end else if (gnt[OWN_IF]) begin
         last_grant_d = OWN_IF;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         last_grant_q <= OWN_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one sram-style memory port between instruction fetch and load/store,
// with byte-lane handling, access checking and a response timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_ADDR_W = 18,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [31:0]           if_rdata,
   output logic                  if_err,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic                  ls_byte,
   input  logic [31:0]           ls_addr,
   input  logic [31:0]           ls_wdata,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [31:0]           ls_rdata,
   output logic                  ls_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  byte_q, byte_d;
   logic [1:0]            off_q, off_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [31:0]           if_rdata_q, if_rdata_d;
   logic                  if_err_q, if_err_d;
   logic [31:0]           ls_rdata_q, ls_rdata_d;
   logic                  ls_err_q, ls_err_d;

   logic        arb_en;
   logic [1:0]  gnt;
   logic        sel_we;
   logic        sel_byte;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_bad;
   logic        resp_load;
   logic        resp_err;
   logic [31:0] resp_data;

   // Grants are suppressed while reset is held so every output reads 0.
   assign arb_en = (state_q == ST_IDLE) && n_reset;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .n_reset (n_reset),
      .en      (arb_en),
      .req     ({ls_req, if_req}),
      .gnt     (gnt)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      byte_d      = byte_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      sel_we      = 1'b0;
      sel_byte    = 1'b0;
      sel_addr    = if_addr;
      sel_wdata   = 32'd0;
      sel_bad     = 1'b0;
      resp_load   = 1'b0;
      resp_err    = 1'b0;
      resp_data   = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               if (gnt[OWN_LS]) begin
                  sel_we    = ls_we;
                  sel_byte  = ls_byte;
                  sel_addr  = ls_addr;
                  sel_wdata = ls_wdata;
               end
               sel_bad = (!sel_byte && (sel_addr[1:0] != 2'b00)) ||
                         ((sel_addr >> (MEM_ADDR_W + 2)) != 32'd0);
               owner_d = gnt[OWN_LS] ? OWN_LS : OWN_IF;
               byte_d  = sel_byte;
               off_d   = sel_addr[1:0];
               cnt_d   = '0;
               if (sel_bad) begin
                  state_d   = ST_RESP;
                  resp_load = 1'b1;
                  resp_err  = 1'b1;
               end else begin
                  state_d     = ST_BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = sel_we;
                  mem_be_d    = be_of(sel_byte, sel_addr[1:0]);
                  mem_addr_d  = sel_addr[MEM_ADDR_W+1:2];
                  mem_wdata_d = !sel_we ? 32'd0 :
                                sel_byte ? {4{sel_wdata[7:0]}} : sel_wdata;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ready || (cnt_q == CNT_LAST)) begin
               state_d     = ST_RESP;
               resp_load   = 1'b1;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_be_d    = 4'b0000;
               mem_addr_d  = '0;
               mem_wdata_d = 32'd0;
               // A ready arriving on the final counted cycle still completes cleanly.
               if (mem_ready) begin
                  if (!mem_we_q) begin
                     resp_data = byte_q ? {24'd0, lane_of(mem_rdata, off_q)} : mem_rdata;
                  end
               end else begin
                  resp_err = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      if_rdata_d = if_rdata_q;
      if_err_d   = if_err_q;
      ls_rdata_d = ls_rdata_q;
      ls_err_d   = ls_err_q;
      if (resp_load) begin
         if (owner_d == OWN_LS) begin
            ls_rdata_d = resp_data;
            ls_err_d   = resp_err;
         end else begin
            if_rdata_d = resp_data;
            if_err_d   = resp_err;
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         byte_q      <= 1'b0;
         off_q       <= 2'b00;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         if_err_q    <= 1'b0;
         ls_rdata_q  <= 32'd0;
         ls_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         byte_q      <= byte_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
      end
   end

   assign if_gnt    = gnt[OWN_IF];
   assign ls_gnt    = gnt[OWN_LS];
   assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
   assign ls_rvalid = (state_q == ST_RESP) && (owner_q == OWN_LS);
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: arbitration, lane handling, rejects, timeout and reset.
module tb_mem_arbiter;

   localparam int MEM_ADDR_W = 18;
   localparam int TIMEOUT    = 8;

   logic                  clk = 1'b0;
   logic                  n_reset;
   logic                  if_req;
   logic [31:0]           if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [31:0]           if_rdata;
   logic                  if_err;
   logic                  ls_req;
   logic                  ls_we;
   logic                  ls_byte;
   logic [31:0]           ls_addr;
   logic [31:0]           ls_wdata;
   logic                  ls_gnt;
   logic                  ls_rvalid;
   logic [31:0]           ls_rdata;
   logic                  ls_err;
   logic                  mem_req;
   logic                  mem_we;
   logic [3:0]            mem_be;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .MEM_ADDR_W (MEM_ADDR_W),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_byte   (ls_byte),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .ls_err    (ls_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ls_setup(input logic we, input logic byt, input logic [31:0] addr,
                           input logic [31:0] wdata);
      ls_req   = 1'b1;
      ls_we    = we;
      ls_byte  = byt;
      ls_addr  = addr;
      ls_wdata = wdata;
   endtask

   initial begin
      logic exp_ls;

      n_reset   = 1'b0;
      if_req    = 1'b1;
      if_addr   = 32'h0000_0100;
      ls_req    = 1'b1;
      ls_we     = 1'b0;
      ls_byte   = 1'b0;
      ls_addr   = 32'h0000_0204;
      ls_wdata  = 32'd0;
      mem_rdata = 32'h5A5A_1234;
      mem_ready = 1'b1;

      // Reset state with both requests already pending.
      repeat (2) @(negedge clk);
      #1;
      check("rst_if_gnt",    32'(if_gnt),    32'd0);
      check("rst_ls_gnt",    32'(ls_gnt),    32'd0);
      check("rst_mem_req",   32'(mem_req),   32'd0);
      check("rst_mem_be",    32'(mem_be),    32'd0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
      check("rst_if_rdata",  if_rdata,       32'd0);

      // Both held from reset with immediate ready: LS, IF, LS, IF.
      @(negedge clk);
      n_reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_ls = (i % 2 == 0);
         check("rr_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
         check("rr_if_gnt", 32'(if_gnt), 32'(!exp_ls));
         @(negedge clk);
         #1;
         check("rr_mem_req",  32'(mem_req),  32'd1);
         check("rr_mem_addr", 32'(mem_addr), exp_ls ? 32'h81 : 32'h40);
         @(negedge clk);
         #1;
         check("rr_ls_rvalid", 32'(ls_rvalid), 32'(exp_ls));
         check("rr_if_rvalid", 32'(if_rvalid), 32'(!exp_ls));
         check("rr_rdata", exp_ls ? ls_rdata : if_rdata, 32'h5A5A_1234);
         $display("[TB] txn rr grant %0d to %s", i, exp_ls ? "LS" : "IF");
         @(negedge clk);
         if (i == 3) begin
            if_req    = 1'b0;
            ls_req    = 1'b0;
            mem_ready = 1'b0;
         end
         #1;
      end

      // IF word read, ready two cycles after mem_req.
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      #1;
      check("if1_gnt",    32'(if_gnt), 32'd1);
      check("if1_ls_gnt", 32'(ls_gnt), 32'd0);
      @(negedge clk);
      if_req = 1'b0;
      #1;
      check("if1_mem_req",   32'(mem_req),  32'd1);
      check("if1_mem_addr",  32'(mem_addr), 32'h40);
      check("if1_mem_be",    32'(mem_be),   32'hF);
      check("if1_mem_we",    32'(mem_we),   32'd0);
      check("if1_mem_wdata", mem_wdata,     32'd0);
      @(negedge clk);
      #1;
      check("if1_wait_req",    32'(mem_req),   32'd1);
      check("if1_wait_rvalid", 32'(if_rvalid), 32'd0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'hE3A0_1005;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("if1_rvalid",    32'(if_rvalid), 32'd1);
      check("if1_rdata",     if_rdata,       32'hE3A0_1005);
      check("if1_err",       32'(if_err),    32'd0);
      check("if1_ls_rvalid", 32'(ls_rvalid), 32'd0);
      check("if1_req_drop",  32'(mem_req),   32'd0);
      @(negedge clk);
      #1;
      check("if1_pulse_end", 32'(if_rvalid), 32'd0);
      check("if1_rdata_hold", if_rdata,      32'hE3A0_1005);
      $display("[TB] txn IF read 0x100 -> 0x%08h", if_rdata);

      // LS byte store at 0x203.
      @(negedge clk);
      ls_setup(1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB);
      #1;
      check("st_gnt", 32'(ls_gnt), 32'd1);
      @(negedge clk);
      ls_req = 1'b0;
      #1;
      check("st_mem_req",   32'(mem_req),  32'd1);
      check("st_mem_addr",  32'(mem_addr), 32'h80);
      check("st_mem_be",    32'(mem_be),   32'h8);
      check("st_mem_wdata", mem_wdata,     32'hABAB_ABAB);
      check("st_mem_we",    32'(mem_we),   32'd1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("st_rvalid", 32'(ls_rvalid), 32'd1);
      check("st_err",    32'(ls_err),    32'd0);
      check("st_rdata",  ls_rdata,       32'd0);
      $display("[TB] txn LS byte store 0x203 be=%b", 4'b1000);

      // LS byte load at 0x202.
      @(negedge clk);
      @(negedge clk);
      ls_setup(1'b0, 1'b1, 32'h0000_0202, 32'd0);
      #1;
      check("ldb_gnt", 32'(ls_gnt), 32'd1);
      @(negedge clk);
      ls_req = 1'b0;
      #1;
      check("ldb_mem_be", 32'(mem_be), 32'h4);
      check("ldb_mem_we", 32'(mem_we), 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1122_3344;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("ldb_rvalid", 32'(ls_rvalid), 32'd1);
      check("ldb_rdata",  ls_rdata,       32'h0000_0022);
      check("ldb_err",    32'(ls_err),    32'd0);
      $display("[TB] txn LS byte load 0x202 -> 0x%08h", ls_rdata);

      // Misaligned word load, then out-of-range word load.
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         @(negedge clk);
         ls_setup(1'b0, 1'b0, (j == 0) ? 32'h0000_0102 : 32'h0100_0000, 32'd0);
         #1;
         check("bad_gnt", 32'(ls_gnt), 32'd1);
         @(negedge clk);
         ls_req = 1'b0;
         #1;
         check("bad_rvalid",  32'(ls_rvalid), 32'd1);
         check("bad_err",     32'(ls_err),    32'd1);
         check("bad_rdata",   ls_rdata,       32'd0);
         check("bad_mem_req", 32'(mem_req),   32'd0);
         @(negedge clk);
         #1;
         check("bad_pulse_end", 32'(ls_rvalid), 32'd0);
         check("bad_mem_req2",  32'(mem_req),   32'd0);
         $display("[TB] txn LS bad word load 0x%08h err=%0d", ls_addr, ls_err);
      end

      // Timeout: ready never arrives, then arrives on the last counted cycle.
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         @(negedge clk);
         if_req  = 1'b1;
         if_addr = 32'h0000_0008;
         #1;
         check("to_gnt", 32'(if_gnt), 32'd1);
         for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if_req = 1'b0;
            if (r == 1 && k == TIMEOUT) begin
               mem_ready = 1'b1;
               mem_rdata = 32'hCAFE_F00D;
            end
            #1;
            check("to_mem_req",   32'(mem_req),   32'd1);
            check("to_no_rvalid", 32'(if_rvalid), 32'd0);
         end
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
         check("to_rvalid",  32'(if_rvalid), 32'd1);
         check("to_err",     32'(if_err),    (r == 0) ? 32'd1 : 32'd0);
         check("to_rdata",   if_rdata,       (r == 0) ? 32'd0 : 32'hCAFE_F00D);
         check("to_req_low", 32'(mem_req),   32'd0);
         $display("[TB] txn IF timeout run %0d err=%0d rdata=0x%08h", r, if_err, if_rdata);
      end

      // Reset asserted in the middle of a BUSY transaction.
      @(negedge clk);
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      @(negedge clk);
      #1;
      check("mr_busy", 32'(mem_req), 32'd1);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check("mr_mem_req",   32'(mem_req),   32'd0);
      check("mr_mem_addr",  32'(mem_addr),  32'd0);
      check("mr_mem_be",    32'(mem_be),    32'd0);
      check("mr_if_gnt",    32'(if_gnt),    32'd0);
      check("mr_if_rvalid", 32'(if_rvalid), 32'd0);
      check("mr_ls_rvalid", 32'(ls_rvalid), 32'd0);
      check("mr_if_rdata",  if_rdata,       32'd0);
      @(negedge clk);
      if_req = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         #1;
         check("mr_no_resp", 32'(if_rvalid | ls_rvalid), 32'd0);
         check("mr_no_req",  32'(mem_req),               32'd0);
      end
      $display("[TB] txn reset mid-BUSY dropped");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
